mp5_phantom_map: RTL
====================

# mp5_phantom_map

Phantom-to-slot address map serving one mp5_stage: records the `(id → fifo, slot)` reported when a phantom packet is pushed, then resolves the matching real packet into an insert request carrying that address. It sits beside each stage, consuming the stage's push-side report and driving the stage's `insert_in` / `addr_in` / `fifo_id_in` / `pkt_in`. It closes the phantom/real-packet loop from the consumer side.

## Interface
- `NUM_PIPELINES`, 8, number of per-stage FIFOs; power of 2.
- `FIFO_SIZE`, 8, slots per FIFO; power of 2.
- `MAP_DEPTH`, 64, map entries; power of 2, ≤ 2^16.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `rec_valid` in 1: record strobe, one entry per cycle.
- `rec_id` in 16: phantom packet id.
- `rec_fifo_id` in $clog2(NUM_PIPELINES): FIFO the phantom was pushed into.
- `rec_addr` in $clog2(FIFO_SIZE): slot address of the phantom.
- `lkp_valid` in 1: real packet offered.
- `lkp_ready` out 1: map accepts the offered packet.
- `lkp_pkt` in Packet: real packet; its `id` is the lookup key.
- `push_busy` in 1: stage is pushing this cycle, so an insert cannot be taken.
- `insert_out` out 1: insert request to the stage.
- `fifo_id_out` out $clog2(NUM_PIPELINES): target FIFO.
- `addr_out` out $clog2(FIFO_SIZE): target slot.
- `pkt_out` out Packet: packet to insert.
- `miss_out` out 1: one-cycle pulse when a lookup found no entry.
- `hit_cnt`, `miss_cnt`, `coll_cnt` out 32 each: statistics counters.

## Operation
- Map entry fields: `valid`, `tag = id[15:IDX_W]`, `fifo_id`, `addr`, where `IDX_W = $clog2(MAP_DEPTH)` and `index = id[IDX_W-1:0]`.
- Record: on `rec_valid`, write `entry[index]` with `valid=1` and the tag, FIFO id and address.
  - If the entry is already valid, the write still happens.
  - If its tag differs, it is a collision: the old entry is lost and `coll_cnt` increments.
- Lookup is accepted on `lkp_valid && lkp_ready`. The map reads `entry[lkp_pkt.id index]`.
  - Hit = `valid && tag match`. On a hit, latch `fifo_id`, `addr` and `lkp_pkt` into the output register, clear the entry's `valid`, increment `hit_cnt`, and move to HOLD.
  - Miss: `miss_out` pulses on the next cycle, there is no insert, the state stays IDLE, and `miss_cnt` increments.
- Output state machine:
  - IDLE: `insert_out=0`, `lkp_ready=1`.
  - HOLD: `insert_out=1`. Outputs stay stable until a cycle with `push_busy=0`, which completes the insert.
    - In that cycle `lkp_ready=1`, so a new hit can reload the register (HOLD→HOLD); otherwise HOLD→IDLE.
    - When `push_busy=1`, `lkp_ready=0`.
- Simultaneous record and lookup:
  - Different indices: both take effect.
  - Same index: the lookup sees the pre-write contents. If the lookup hits and clears `valid` in the same cycle as the record write, the record write wins (entry ends valid with the new data).
- Counters are 32-bit and saturate at 0xFFFF_FFFF.

## Timing
- Record to usable: a record at edge N is visible to a lookup accepted at edge N+1.
- Lookup latency: accept at edge N gives `insert_out` / `miss_out` in cycle N+1 (registered).
- `insert_out` is held across any number of `push_busy` cycles. The insert completes on the first edge where `insert_out && !push_busy`.
- Reset (including mid-HOLD):
  - All `valid` bits clear in one cycle; state returns to IDLE.
  - `insert_out=0`, `miss_out=0`, `fifo_id_out=0`, `addr_out=0`, `pkt_out=0`, counters = 0.
  - `lkp_ready=1` from the first cycle after reset deasserts.
  - Inputs during reset are ignored.
- Wrap-around: ids differing only in upper bits alias to the same index, and the tag disambiguates them. Id 0xFFFF is ordinary.

## Configuration
- `MP5_MAP_STATS_EN`:
  - Defined: the three counters are implemented as specified.
  - Undefined: the counters are not built and `hit_cnt`, `miss_cnt`, `coll_cnt` are driven constant 0. All other behaviour is identical.

## Test plan
- Record id 0x0005 (fifo 3, addr 6); two cycles later look up id 0x0005 → cycle+1: `insert_out=1`, `fifo_id_out=3`, `addr_out=6`, `pkt_out` equals the input, `hit_cnt=1`. A second lookup of 0x0005 → `miss_out=1`, `miss_cnt=1`.
- Look up id 0x0042 with no record → `miss_out` pulse one cycle, `insert_out` stays 0, `lkp_ready` stays 1.
- Record 0x0007 then 0x0047 (same index, MAP_DEPTH=64) → `coll_cnt=1`; lookup 0x0007 misses, lookup 0x0047 hits.
- Hit with `push_busy=1` for 3 cycles → `insert_out` and `addr_out` stable for 4 cycles and `lkp_ready=0` for 3 cycles. A back-to-back lookup offered in the release cycle is accepted.
- Same-cycle record 0x0010 (fifo 1, addr 2) and lookup 0x0010 against a prior record (fifo 4, addr 5) → insert uses fifo 4 / addr 5, and the entry remains valid with fifo 1 / addr 2.
- Assert `rst` while in HOLD → next cycle `insert_out=0`, counters 0; a lookup of a previously recorded id misses.

Source files
------------

// File: rtl/mp5_phantom_map.sv
// mp5_phantom_map: records phantom (id -> fifo, slot) reports and turns the matching real packet
// into a held insert request for the stage. Statistics counters are built only with MP5_MAP_STATS_EN.
package mp5_phantom_map_pkg;
  typedef struct packed {
    logic [15:0] id;
    logic [31:0] data;
  } Packet;
endpackage

module mp5_phantom_map
  import mp5_phantom_map_pkg::*;
#(
  parameter int NUM_PIPELINES = 8,
  parameter int FIFO_SIZE     = 8,
  parameter int MAP_DEPTH     = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rec_valid,
  input  logic [15:0]                      rec_id,
  input  logic [$clog2(NUM_PIPELINES)-1:0] rec_fifo_id,
  input  logic [$clog2(FIFO_SIZE)-1:0]     rec_addr,
  input  logic                             lkp_valid,
  output logic                             lkp_ready,
  input  Packet                            lkp_pkt,
  input  logic                             push_busy,
  output logic                             insert_out,
  output logic [$clog2(NUM_PIPELINES)-1:0] fifo_id_out,
  output logic [$clog2(FIFO_SIZE)-1:0]     addr_out,
  output Packet                            pkt_out,
  output logic                             miss_out,
  output logic [31:0]                      hit_cnt,
  output logic [31:0]                      miss_cnt,
  output logic [31:0]                      coll_cnt
);

  localparam int FW    = $clog2(NUM_PIPELINES);
  localparam int AW    = $clog2(FIFO_SIZE);
  localparam int IDX_W = $clog2(MAP_DEPTH);
  // A full 16-bit index leaves no tag bits; keep one constant-zero bit so every tag matches.
  localparam int TAG_W = (IDX_W < 16) ? 16 - IDX_W : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  function automatic logic [TAG_W-1:0] tag_of(input logic [15:0] id);
    logic [16:0] ext;
    ext = {1'b0, id} >> IDX_W;
    return ext[TAG_W-1:0];
  endfunction

  logic [MAP_DEPTH-1:0] entry_valid;
  logic [TAG_W-1:0]     entry_tag  [MAP_DEPTH];
  logic [FW-1:0]        entry_fifo [MAP_DEPTH];
  logic [AW-1:0]        entry_addr [MAP_DEPTH];

  logic [0:0]       state;
  logic [IDX_W-1:0] rec_idx;
  logic [IDX_W-1:0] lkp_idx;
  logic             accept;
  logic             hit;
  logic             miss;

  assign rec_idx    = rec_id[IDX_W-1:0];
  assign lkp_idx    = lkp_pkt.id[IDX_W-1:0];
  assign lkp_ready  = (state == ST_IDLE) || !push_busy;
  assign accept     = lkp_valid && lkp_ready;
  assign hit        = accept && entry_valid[lkp_idx] && (entry_tag[lkp_idx] == tag_of(lkp_pkt.id));
  assign miss       = accept && !hit;
  assign insert_out = (state == ST_HOLD);

  // The record set comes after the hit clear so a same-index record write wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_valid <= '0;
      state       <= ST_IDLE;
      miss_out    <= 1'b0;
      fifo_id_out <= '0;
      addr_out    <= '0;
      pkt_out     <= '0;
    end else begin
      miss_out <= miss;
      if (hit) begin
        entry_valid[lkp_idx] <= 1'b0;
        state                <= ST_HOLD;
        fifo_id_out          <= entry_fifo[lkp_idx];
        addr_out             <= entry_addr[lkp_idx];
        pkt_out              <= lkp_pkt;
      end else if ((state == ST_HOLD) && !push_busy) begin
        state <= ST_IDLE;
      end
      if (rec_valid) begin
        entry_valid[rec_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rec_valid) begin
      entry_tag[rec_idx]  <= tag_of(rec_id);
      entry_fifo[rec_idx] <= rec_fifo_id;
      entry_addr[rec_idx] <= rec_addr;
    end
  end

`ifdef MP5_MAP_STATS_EN
  logic        coll;
  logic [31:0] hit_q;
  logic [31:0] miss_q;
  logic [31:0] coll_q;

  assign coll = rec_valid && entry_valid[rec_idx] && (entry_tag[rec_idx] != tag_of(rec_id));

  // Saturating counters: they stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
      coll_q <= '0;
    end else begin
      if (hit && (hit_q != 32'hFFFF_FFFF)) hit_q <= hit_q + 32'd1;
      if (miss && (miss_q != 32'hFFFF_FFFF)) miss_q <= miss_q + 32'd1;
      if (coll && (coll_q != 32'hFFFF_FFFF)) coll_q <= coll_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
  assign coll_cnt = coll_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
  assign coll_cnt = '0;
`endif

endmodule
